// File: rtl/bilerp_pkg.sv
// bilerp_pkg: state encoding, fetch constants and the bilinear datapath
package bilerp_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        CALC    = 2'd2,
        PRESENT = 2'd3
    } state_t;

    localparam int SCALE_LOG2 = 4;
    localparam logic [2:0] FETCH_LAST = 3'd4;

    // Neighbour slots in fetch order; bit 0 selects sx1, bit 1 selects sy1
    localparam logic [1:0] NBR_00 = 2'd0;
    localparam logic [1:0] NBR_01 = 2'd1;
    localparam logic [1:0] NBR_10 = 2'd2;
    localparam logic [1:0] NBR_11 = 2'd3;

    // 2-bit samples widened by replication, horizontal then vertical lerp, top nibble kept
    function automatic logic [3:0] bilerp(input logic [1:0] n00, input logic [1:0] n01,
                                          input logic [1:0] n10, input logic [1:0] n11,
                                          input logic [3:0] alpha, input logic [3:0] beta);
        logic [11:0] top, bot, v;
        top = 12'({n00, n00}) * (12'd16 - 12'(alpha)) + 12'({n01, n01}) * 12'(alpha);
        bot = 12'({n10, n10}) * (12'd16 - 12'(alpha)) + 12'({n11, n11}) * 12'(alpha);
        v   = top * (12'd16 - 12'(beta)) + bot * 12'(beta);
        return v[11:8];
    endfunction

endpackage

// File: rtl/bilerp_coord_gen.sv
// bilerp_coord_gen: output raster counters, edge clamp, neighbour address and eol/last flags (tile ports under BILERP_NBR_CACHE_EN)
import bilerp_pkg::*;

module bilerp_coord_gen #(
    parameter int SRC_W  = 4,
    parameter int SRC_H  = 2,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              adv,
    input  logic [1:0]        sel,
    output logic [ADDR_W-1:0] addr,
    output logic [3:0]        alpha,
    output logic [3:0]        beta,
    output logic              eol,
`ifdef BILERP_NBR_CACHE_EN
    output logic [$clog2(SRC_W)+$clog2(SRC_H)-1:0] tile,
    output logic [$clog2(SRC_W)+$clog2(SRC_H)-1:0] nxt_tile,
`endif
    output logic              last
);

    localparam int SX_W = $clog2(SRC_W);
    localparam int SY_W = $clog2(SRC_H);
    localparam int OX_W = SX_W + SCALE_LOG2;
    localparam int OY_W = SY_W + SCALE_LOG2;

    logic [OX_W-1:0] ox_q, ox_d, ox_n;
    logic [OY_W-1:0] oy_q, oy_d, oy_n;
    logic [SX_W-1:0] sx, sx1;
    logic [SY_W-1:0] sy, sy1;

    // Split coordinates, clamp the +1 neighbour at the far edge, compute next raster position
    always_comb begin
        sx    = ox_q[OX_W-1:SCALE_LOG2];
        sy    = oy_q[OY_W-1:SCALE_LOG2];
        alpha = ox_q[SCALE_LOG2-1:0];
        beta  = oy_q[SCALE_LOG2-1:0];
        sx1   = (sx == SX_W'(SRC_W - 1)) ? sx : sx + SX_W'(1);
        sy1   = (sy == SY_W'(SRC_H - 1)) ? sy : sy + SY_W'(1);
        eol   = ox_q == OX_W'((SRC_W << SCALE_LOG2) - 1);
        last  = eol && (oy_q == OY_W'((SRC_H << SCALE_LOG2) - 1));
        ox_n  = eol ? '0 : ox_q + OX_W'(1);
        oy_n  = eol ? oy_q + OY_W'(1) : oy_q;
        ox_d  = clr ? '0 : adv ? ox_n : ox_q;
        oy_d  = clr ? '0 : adv ? oy_n : oy_q;
        addr  = ADDR_W'(sel[1] ? sy1 : sy) * ADDR_W'(SRC_W) + ADDR_W'(sel[0] ? sx1 : sx);
`ifdef BILERP_NBR_CACHE_EN
        tile     = {sx, sy};
        nxt_tile = {ox_n[OX_W-1:SCALE_LOG2], oy_n[OY_W-1:SCALE_LOG2]};
`endif
    end

    // Raster position registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ox_q <= '0;
            oy_q <= '0;
        end else begin
            ox_q <= ox_d;
            oy_q <= oy_d;
        end
    end

endmodule

// File: rtl/bilerp_scaler_ctrl.sv
// bilerp_scaler_ctrl: fetch/calc/present sequencer for the 16x bilinear upscaler (neighbour cache under BILERP_NBR_CACHE_EN)
import bilerp_pkg::*;

module bilerp_scaler_ctrl #(
    parameter int SRC_W  = 4,
    parameter int SRC_H  = 2,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [1:0]        rd_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [3:0]        pix_data,
    output logic              pix_eol,
    output logic              pix_last,
    output logic              done
);

    state_t            state_q, state_d;
    logic [2:0]        fcnt_q, fcnt_d;
    logic [1:0]        n_q [4];
    logic [1:0]        n_d [4];
    logic [3:0]        pix_data_q, pix_data_d;
    logic              pix_valid_q, pix_valid_d;
    logic              pix_eol_q, pix_eol_d;
    logic              pix_last_q, pix_last_d;
    logic              done_q, done_d;
    logic              clr, adv, hit, eol, last;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        alpha, beta;

`ifdef BILERP_NBR_CACHE_EN
    localparam int T_W = $clog2(SRC_W) + $clog2(SRC_H);
    logic [T_W-1:0] tile, nxt_tile, tag_q, tag_d;
    logic           tag_v_q, tag_v_d;
    assign hit = tag_v_q && (tag_q == nxt_tile);
`else
    assign hit = 1'b0;
`endif

    bilerp_coord_gen #(.SRC_W(SRC_W), .SRC_H(SRC_H), .ADDR_W(ADDR_W)) u_coord (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .adv      (adv),
        .sel      (fcnt_q[1:0]),
        .addr     (addr),
        .alpha    (alpha),
        .beta     (beta),
        .eol      (eol),
`ifdef BILERP_NBR_CACHE_EN
        .tile     (tile),
        .nxt_tile (nxt_tile),
`endif
        .last     (last)
    );

    assign busy      = state_q != IDLE;
    assign rd_en     = (state_q == FETCH) && (fcnt_q != FETCH_LAST);
    assign rd_addr   = rd_en ? addr : '0;
    assign pix_valid = pix_valid_q;
    assign pix_data  = pix_data_q;
    assign pix_eol   = pix_eol_q;
    assign pix_last  = pix_last_q;
    assign done      = done_q;

    // Next state: reads issue on fcnt 0..3, data lands one cycle later on fcnt 1..4
    always_comb begin
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        n_d         = n_q;
        pix_data_d  = pix_data_q;
        pix_valid_d = pix_valid_q;
        pix_eol_d   = pix_eol_q;
        pix_last_d  = pix_last_q;
        done_d      = 1'b0;
        clr         = 1'b0;
        adv         = 1'b0;
`ifdef BILERP_NBR_CACHE_EN
        tag_d       = tag_q;
        tag_v_d     = tag_v_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef BILERP_NBR_CACHE_EN
                tag_v_d = 1'b0;
`endif
                if (start) begin
                    state_d = FETCH;
                    fcnt_d  = '0;
                    clr     = 1'b1;
                end
            end
            FETCH: begin
                fcnt_d = fcnt_q + 3'd1;
                if (fcnt_q != 3'd0) n_d[fcnt_q[1:0] - 2'd1] = rd_data;
                if (fcnt_q == FETCH_LAST) begin
                    state_d = CALC;
`ifdef BILERP_NBR_CACHE_EN
                    tag_d   = tile;
                    tag_v_d = 1'b1;
`endif
                end
            end
            CALC: begin
                pix_data_d  = bilerp(n_q[NBR_00], n_q[NBR_01], n_q[NBR_10], n_q[NBR_11], alpha, beta);
                pix_valid_d = 1'b1;
                pix_eol_d   = eol;
                pix_last_d  = last;
                state_d     = PRESENT;
            end
            PRESENT: begin
                if (pix_ready) begin
                    pix_valid_d = 1'b0;
                    pix_eol_d   = 1'b0;
                    pix_last_d  = 1'b0;
                    adv         = 1'b1;
                    fcnt_d      = '0;
                    done_d      = pix_last_q;
                    state_d     = pix_last_q ? IDLE : hit ? CALC : FETCH;
                end
            end
        endcase
    end

    // Sequencer, neighbour and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            fcnt_q      <= '0;
            n_q         <= '{default: '0};
            pix_data_q  <= '0;
            pix_valid_q <= 1'b0;
            pix_eol_q   <= 1'b0;
            pix_last_q  <= 1'b0;
            done_q      <= 1'b0;
`ifdef BILERP_NBR_CACHE_EN
            tag_q       <= '0;
            tag_v_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            n_q         <= n_d;
            pix_data_q  <= pix_data_d;
            pix_valid_q <= pix_valid_d;
            pix_eol_q   <= pix_eol_d;
            pix_last_q  <= pix_last_d;
            done_q      <= done_d;
`ifdef BILERP_NBR_CACHE_EN
            tag_q       <= tag_d;
            tag_v_q     <= tag_v_d;
`endif
        end
    end

endmodule

// File: tb/tb_bilerp_scaler_ctrl.sv
// tb_bilerp_scaler_ctrl: table vectors, random back-pressured frame and reset abort against a raster model
module tb_bilerp_scaler_ctrl;

    localparam int SRC_W = 4, SRC_H = 2, ADDR_W = 8;
    localparam int OW = 16 * SRC_W, OH = 16 * SRC_H, NPIX = OW * OH;
`ifdef BILERP_NBR_CACHE_EN
    localparam int EXP_RD = 512;
`else
    localparam int EXP_RD = 8192;
`endif

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, pix_ready = 1'b0;
    logic busy, rd_en, pix_valid, pix_eol, pix_last, done;
    logic [ADDR_W-1:0] rd_addr;
    logic [1:0] rd_data = 2'b00;
    logic [3:0] pix_data;

    logic [1:0] fb [SRC_W*SRC_H];
    logic [3:0] got_pix [NPIX];
    logic       got_eol [NPIX];
    logic       got_last [NPIX];
    int total = 0, bad = 0;
    int n_acc, n_rd, n_done, n_hold_err, n_rd_bad, n_addr_err;
    logic prev_stall = 1'b0;
    logic [5:0] prev_out = '0;

    typedef struct {
        logic [15:0] fbv;
        int          ox;
        int          oy;
        logic [3:0]  exp;
    } vec_t;
    vec_t vecs [9];

    bilerp_scaler_ctrl #(.SRC_W(SRC_W), .SRC_H(SRC_H), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_data  (pix_data),
        .pix_eol   (pix_eol),
        .pix_last  (pix_last),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Framebuffer RAM with one cycle read latency
    always @(posedge clk) rd_data <= rd_en ? fb[rd_addr[2:0]] : 2'b00;

    // Stream monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_en) n_rd++;
            if (rd_en && pix_valid) n_rd_bad++;
            if (rd_en && rd_addr >= ADDR_W'(SRC_W * SRC_H)) n_addr_err++;
            if (done) n_done++;
            if (prev_stall && {pix_valid, pix_data, pix_eol, pix_last} != {1'b1, prev_out}) n_hold_err++;
            prev_stall = pix_valid && !pix_ready;
            prev_out = {pix_data, pix_eol, pix_last};
            if (pix_valid && pix_ready) begin
                if (n_acc < NPIX) begin
                    got_pix[n_acc] = pix_data;
                    got_eol[n_acc] = pix_eol;
                    got_last[n_acc] = pix_last;
                end
                n_acc++;
            end
        end
    end

    // Reference: bilinear weights from source coordinates, samples scaled to 4 bits (x5)
    function automatic logic [3:0] ref_pix(input int ox, input int oy);
        int sx, sy, sx1, sy1, a, b, p00, p01, p10, p11, top, bot;
        sx = ox / 16; sy = oy / 16; a = ox % 16; b = oy % 16;
        sx1 = (sx + 1 > SRC_W - 1) ? SRC_W - 1 : sx + 1;
        sy1 = (sy + 1 > SRC_H - 1) ? SRC_H - 1 : sy + 1;
        p00 = int'(fb[sy * SRC_W + sx]) * 5;
        p01 = int'(fb[sy * SRC_W + sx1]) * 5;
        p10 = int'(fb[sy1 * SRC_W + sx]) * 5;
        p11 = int'(fb[sy1 * SRC_W + sx1]) * 5;
        top = p00 * (16 - a) + p01 * a;
        bot = p10 * (16 - a) + p11 * a;
        return 4'((top * (16 - b) + bot * b) / 256);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic load_fb(input logic [15:0] v);
        for (int j = 0; j < SRC_W * SRC_H; j++) fb[j] = v[2*j +: 2];
    endtask

    task automatic clear_mon();
        n_acc = 0; n_rd = 0; n_done = 0; n_hold_err = 0; n_rd_bad = 0; n_addr_err = 0;
        prev_stall = 1'b0;
    endtask

    task automatic start_frame();
        int lat = 99;
        clear_mon();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (pix_valid) begin
                lat = k;
                break;
            end
        end
        chk("start_latency", lat, 6);
    endtask

    task automatic run_frame(input bit stress);
        int stall = 0;
        bit stalled = 1'b0;
        pix_ready = 1'b1;
        start_frame();
        for (int c = 0; c < 40000 && n_done == 0; c++) begin
            if (stress && !stalled && n_acc >= 100 && pix_valid) begin
                stall = 10;
                stalled = 1'b1;
            end
            pix_ready = (stall > 0) ? 1'b0 : stress ? ($urandom_range(3) != 0) : 1'b1;
            if (stall > 0) stall--;
            @(posedge clk); #1;
        end
        pix_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input string tag);
        int m = 0;
        for (int i = 0; i < NPIX; i++)
            if (got_pix[i] != ref_pix(i % OW, i / OW) || got_eol[i] != (i % OW == OW - 1) ||
                got_last[i] != (i == NPIX - 1)) m++;
        chk({tag, "_pixels"}, m, 0);
        chk({tag, "_count"}, n_acc, NPIX);
        chk({tag, "_done"}, n_done, 1);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_hold"}, n_hold_err, 0);
        chk({tag, "_rd_present"}, n_rd_bad, 0);
        chk({tag, "_addr_range"}, n_addr_err, 0);
        chk({tag, "_rd_count"}, n_rd, EXP_RD);
    endtask

    initial begin
        int m;
        vecs[0] = '{16'h0000, 0, 0, 4'h0};
        vecs[1] = '{16'h0000, 63, 31, 4'h0};
        vecs[2] = '{16'hFCFC, 8, 0, 4'h7};
        vecs[3] = '{16'hFCFC, 4, 0, 4'h3};
        vecs[4] = '{16'hFCFC, 63, 31, 4'hF};
        vecs[5] = '{16'h8000, 63, 31, 4'hA};
        vecs[6] = '{16'h8000, 0, 0, 4'h0};
        vecs[7] = '{16'h0309, 4, 12, 4'hA};
        vecs[8] = '{16'h0309, 8, 8, 4'h7};

        clear_mon();
        load_fb(16'hFFFF);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", int'(pix_valid), 0);
        chk("reset_rd_en", int'(rd_en), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_data", int'(pix_data), 0);
        #2 rst_n = 1'b1;

        // All-3 frame aborted by reset while a fetch is in flight
        pix_ready = 1'b1;
        start_frame();
        for (int c = 0; c < 400 && !(rd_en && n_acc >= 5); c++) begin
            @(posedge clk); #1;
        end
        chk("abort_pix_data_before", int'(pix_data), 15);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_rd_en", int'(rd_en), 0);
        chk("abort_valid", int'(pix_valid), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_flags", int'({pix_eol, pix_last, done}), 0);
        chk("abort_data", int'(pix_data), 0);
        m = 0;
        for (int i = 0; i < n_acc && i < NPIX; i++) if (got_pix[i] != 4'hF) m++;
        chk("abort_pixels_all_f", m, 0);
        chk("abort_pixels_seen", int'(n_acc >= 5), 1);
        chk("abort_no_done", n_done, 0);
        @(posedge clk); #3 rst_n = 1'b1;

        // Table vectors: one full frame per framebuffer image, then spot checks
        for (int i = 0; i < 9; i++) begin
            if (i == 0 || vecs[i].fbv != vecs[i-1].fbv) begin
                load_fb(vecs[i].fbv);
                run_frame(1'b0);
                check_frame($sformatf("frame_%04h", vecs[i].fbv));
            end
            chk($sformatf("vec%0d_pix", i), int'(got_pix[vecs[i].oy * OW + vecs[i].ox]), int'(vecs[i].exp));
            chk($sformatf("vec%0d_eol", i), int'(got_eol[vecs[i].oy * OW + vecs[i].ox]), int'(vecs[i].ox == OW - 1));
        end

        // Random image with random back-pressure and a 10-cycle stall
        for (int j = 0; j < SRC_W * SRC_H; j++) fb[j] = 2'($urandom_range(3));
        run_frame(1'b1);
        check_frame("random_bp");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
